// File: rtl/adder_rr_arbiter.sv
// Round-robin sequencer sharing one LAT-cycle adder among four requesters; one op in flight.
// Grant one cycle after accept edge, rsp_valid LAT cycles later; requests wait (level-sampled) while busy.
module adder_rr_arbiter #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] req_a,
    input  logic [4*W-1:0] req_b,
    input  logic [3:0]     req_cin,
    output logic [3:0]     grant,
    output logic           busy,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    output logic           add_cin,
    input  logic [W-1:0]   add_sum,
    input  logic           add_carry,
    output logic           rsp_valid,
    output logic [1:0]     rsp_id,
    output logic [W-1:0]   rsp_sum,
    output logic           rsp_carry
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

    state_t         state_q, state_d;
    logic [1:0]     last_q, last_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic           opc_q, opc_d;
    logic [3:0]     grant_q, grant_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [1:0]     rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_carry_q, rsp_carry_d;

    logic [1:0]     win, idx;
    logic           found;
    logic [W-1:0]   win_a, win_b;
    logic           win_c;

    // Search starts just past the last winner so it ends up lowest priority.
    always_comb begin
        win   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        win_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                win_a = req_a[i*W +: W];
                win_b = req_b[i*W +: W];
                win_c = req_cin[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opc_d       = opc_q;
        grant_d     = 4'b0000;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d  = S_BUSY;
                    last_d   = win;
                    opa_d    = win_a;
                    opb_d    = win_b;
                    opc_d    = win_c;
                    grant_d  = 4'b0001 << win;
                    rsp_id_d = win;
                    cnt_d    = 4'd0;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_sum_d   = add_sum;
                    rsp_carry_d = add_carry;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 2'd3;
            cnt_q       <= 4'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= 1'b0;
            grant_q     <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign add_a     = opa_q;
    assign add_b     = opb_q;
    assign add_cin   = opc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one registered W-bit ripple-carry adder among four requesters. It accepts one operation at a time and holds the operands stable on the adder inputs for the adder's fixed latency. It captures {carry, sum} and returns the result to the granted requester, tagged with that requester's ID. It sits between the ALU front-end request ports and the single adder instance.

## Interface
- W, 8, operand and sum width.
- LAT, 2, adder latency in clocks from operand apply to valid result. Legal range 1..15.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  4  per-requester request level; bit i = requester i.
- req_a  in  4*W  operand A, packed; requester i uses bits [i*W +: W].
- req_b  in  4*W  operand B, packed in the same way.
- req_cin  in  4  carry-in per requester.
- grant  out  4  one-hot, one-cycle pulse: request accepted.
- busy  out  1  high whenever the FSM is not IDLE.
- add_a  out  W  operand A to the shared adder.
- add_b  out  W  operand B to the shared adder.
- add_cin  out  1  carry-in to the shared adder.
- add_sum  in  W  sum from the shared adder.
- add_carry  in  1  carry-out from the shared adder.
- rsp_valid  out  1  one-cycle pulse: result available.
- rsp_id  out  2  index of the requester that owns the result.
- rsp_sum  out  W  captured sum.
- rsp_carry  out  1  captured carry-out.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req != 0, select the winner with round-robin and go to BUSY.
  - Search starts at last+1 mod 4 and wraps; the first set bit wins.
  - On entering BUSY: last <= winner; latch the winner's a, b, cin into operand registers; grant[winner] <= 1 for one cycle; rsp_id <= winner; cnt <= 0.
- BUSY:
  - If cnt == LAT-1: capture add_sum and add_carry into rsp_sum and rsp_carry, assert rsp_valid, go to DONE.
  - Otherwise cnt <= cnt+1.
- DONE: deassert rsp_valid and go to IDLE. No arbitration happens in DONE.
- add_a, add_b and add_cin are driven only from the operand registers. They stay stable from the grant edge until the next grant.
- The block does no arithmetic. rsp_carry and rsp_sum are exactly what the adder returned at the capture edge.
- Requester obligations:
  - Hold req and operands stable until grant is seen.
  - Drop req in the cycle after grant unless another operation is wanted.
  - A req that stays high is treated as a new request at the next IDLE.
- Requests arriving in BUSY or DONE wait. Nothing is queued; req is level-sampled only in IDLE.
- Operands change or req deasserts before grant: the operation is never issued. This is not an error.

## Timing
- Reset (asynchronous, immediate) sets the FSM to IDLE, last = 3, cnt = 0 and operand registers to 0.
- Output values during reset: grant = 0, busy = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_carry = 0, add_a = 0, add_b = 0, add_cin = 0.
- Because last = 3 after reset, requester 0 has the highest priority for the first arbitration.
- Grant edge E0 (FSM in IDLE, req != 0):
  - grant and busy are high in the cycle after E0.
  - Operands appear on add_* in the same cycle.
- Capture edge is E0+LAT. rsp_valid is high for exactly one cycle after it.
- The FSM returns to IDLE at E0+LAT+1. The earliest next grant edge is E0+LAT+2.
- Throughput: one operation per LAT+2 cycles.
- Simultaneous requests: exactly one grant per arbitration. A requester that was just served has the lowest priority at the next arbitration.
- If rst asserts mid-operation, the in-flight operation is dropped and no rsp_valid is issued. After release, arbitration restarts from requester 0.
- rst released while req != 0: the first grant happens at the first rising edge after release.

## Test plan
- Single request, adder model with LAT=2: req=0001, a=100, b=27, cin=1 -> grant=0001 after E0; rsp_valid at E0+2 with rsp_id=0, rsp_sum=128, rsp_carry=0; busy low by E0+3.
- Carry boundary: requester 2 sends a=255, b=255, cin=1 -> rsp_sum=255, rsp_carry=1. Then a=0, b=0, cin=0 -> rsp_sum=0, rsp_carry=0.
- All four requesting from reset and holding req until granted -> grants in order 0,1,2,3. Grants are spaced LAT+2=4 cycles apart. Each rsp_id matches its grant and each result equals a+b+cin.
- Requesters 0 and 2 held high continuously -> grants alternate 0,2,0,2 with no starvation.
- Reset mid-operation: assert rst one cycle after the grant -> no rsp_valid, all outputs 0 immediately. After release with req=1000, the first grant is to requester 3.
- Random regression, 16 operations per requester: random operands and cin with random req patterns, run at both LAT=1 and LAT=15. A scoreboard checks every response for correct ID, value, latency and the one-hot grant property.
